// File: rtl/i2c_cmd_queue.sv
// Command queue in front of the I2C master: buffers commands, issues them one at a time,
// retries NACKed transfers with a backoff, and returns one response word per command.
module i2c_cmd_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned RETRIES = 2,
  parameter int unsigned BACKOFF = 800
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [31:0]            push_cmd,
  input  logic                   push_read,
  input  logic                   flush,
  output logic [31:0]            ctrl_data,
  output logic                   wr_ctrl,
  output logic                   read,
  input  logic [31:0]            status,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(BACKOFF + 1);

  localparam logic [3:0]    MaxRetry  = 4'(RETRIES);
  localparam logic [TW-1:0] BackoffLd = TW'(BACKOFF);
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StBackoff,
    StResult
  } state_e;

  state_e          state;
  logic [32:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [32:0]     head;
  logic            push_en;
  logic            pop_en;
  logic            busy;
  logic [3:0]      attempts;
  logic [TW-1:0]   timer;
  logic [1:0]      wb_cnt;
  logic            unused_status;

  assign busy          = status[31];
  assign unused_status = ^status[27:8];
  assign head          = mem[rd_ptr];

  // Full blocks a push even when the same cycle pops; flush drops a concurrent push.
  assign push_ready = (level != FullLevel);
  assign push_en    = push_valid && push_ready && !flush;
  assign pop_en     = (state == StIdle) && (level != '0) && !busy && !rsp_valid && !flush;

  assign idle = (level == '0) && (state == StIdle) && !rsp_valid;

  // Storage carries no reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= {push_read, push_cmd};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + LW'(push_en) - LW'(pop_en);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      ctrl_data <= '0;
      read      <= 1'b0;
      wr_ctrl   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      attempts  <= '0;
      timer     <= '0;
      wb_cnt    <= '0;
    end else begin
      wr_ctrl <= 1'b0;
      case (state)
        StIdle: begin
          // ctrl_data/read change only here so they stay stable across retries.
          if (pop_en) begin
            {read, ctrl_data} <= head;
            attempts          <= 4'd1;
            state             <= StIssue;
          end
        end

        StIssue: begin
          wr_ctrl <= 1'b1;
          wb_cnt  <= '0;
          state   <= StWaitBusy;
        end

        StWaitBusy: begin
          // A master that never goes busy lost the strobe; reissue without
          // charging an attempt.
          if (busy) begin
            state <= StWaitDone;
          end else if (wb_cnt == 2'd3) begin
            state <= StIssue;
          end else begin
            wb_cnt <= wb_cnt + 2'd1;
          end
        end

        StWaitDone: begin
          if (!busy) begin
            rsp_data <= {1'b0, status[30:28], attempts, ctrl_data[23:16], 8'h00, status[7:0]};
            if ((status[30] || status[29]) && (attempts <= MaxRetry)) begin
              attempts <= attempts + 4'd1;
              timer    <= BackoffLd;
              state    <= StBackoff;
            end else begin
              rsp_valid <= 1'b1;
              state     <= StResult;
            end
          end
        end

        StBackoff: begin
          timer <= timer - 1'b1;
          if (timer <= TW'(1)) begin
            state <= StIssue;
          end
        end

        StResult: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Bench for i2c_cmd_queue: behavioural I2C master model, vector table and response scoreboard.
module tb_i2c_cmd_queue;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned RETRIES = 2;
  localparam int unsigned BACKOFF = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_cmd = '0;
  logic        push_read = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ctrl_data;
  logic        wr_ctrl;
  logic        read;
  logic [31:0] status;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [3:0]  level;
  logic        idle;

  i2c_cmd_queue #(
    .DEPTH   (DEPTH),
    .RETRIES (RETRIES),
    .BACKOFF (BACKOFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_cmd   (push_cmd),
    .push_read  (push_read),
    .flush      (flush),
    .ctrl_data  (ctrl_data),
    .wr_ctrl    (wr_ctrl),
    .read       (read),
    .status     (status),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .level      (level),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Master model configuration, written only by the stimulus process.
  logic       m_init = 1'b0;
  logic       m_hold = 1'b0;
  int         drop_base = 0;
  int         drop_limit = 0;
  int         nack_base = 0;
  int         nack_limit = 0;
  logic       nack_data = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  // Master model state.
  logic        m_busy, m_anack, m_dnack, m_rd;
  logic [7:0]  m_rdata_q;
  logic [2:0]  m_cnt;
  int          cyc = 0;
  int          fall_cyc = 0;
  int          pulses = 0;
  int          acc = 0;
  logic [32:0] p_ctrl_q[$];
  int          p_idle_q[$];

  assign status = m_init ? 32'h8400_0000 : {m_busy, m_anack, m_dnack, m_rd, 20'h0, m_rdata_q};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy    <= 1'b0;
      m_anack   <= 1'b0;
      m_dnack   <= 1'b0;
      m_rd      <= 1'b0;
      m_rdata_q <= 8'h00;
      m_cnt     <= 3'd0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (m_cnt != 3'd0) m_cnt <= m_cnt - 3'd1;
        else if (!m_hold) begin
          m_busy   <= 1'b0;
          fall_cyc <= cyc;
        end
      end else if (wr_ctrl) begin
        pulses <= pulses + 1;
        p_ctrl_q.push_back({read, ctrl_data});
        p_idle_q.push_back(cyc - fall_cyc);
        if (pulses - drop_base >= drop_limit) begin
          acc       <= acc + 1;
          m_busy    <= 1'b1;
          m_cnt     <= 3'd4;
          m_anack   <= (acc - nack_base < nack_limit) && !nack_data;
          m_dnack   <= (acc - nack_base < nack_limit) && nack_data;
          m_rd      <= read;
          m_rdata_q <= m_rdata;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] cmd;
    logic        rd;
    int          drops;
    int          nacks;
    logic        dn;
    logic [7:0]  rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    n_vec++;
    if (act < lim) begin
      n_err++;
      $display("FAIL %s: got %0d, want >= %0d", name, act, lim);
    end
  endtask

  task automatic push_one(input logic [31:0] c, input logic r);
    @(negedge clk);
    push_valid = 1'b1;
    push_cmd   = c;
    push_read  = r;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = rsp_valid;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: rsp_valid timeout, got 0, want 1", name);
    end
  endtask

  task automatic drain(input string name);
    bit ok;
    wait_valid(name, ok);
    if (ok) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: unexpected response %h, want none", name, rsp_data);
      end else begin
        check32(name, rsp_data, sb.pop_front());
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int exp_p;
    int nr;

    vecs[0] = '{32'h1A10_5500, 1'b0, 0, 0, 1'b0, 8'h00, 32'h0110_0000};
    vecs[1] = '{32'h1A10_0000, 1'b1, 0, 0, 1'b0, 8'h3C, 32'h1110_003C};
    vecs[2] = '{32'h1A20_5500, 1'b0, 0, 3, 1'b0, 8'h00, 32'h4320_0000};
    vecs[3] = '{32'h1A30_5500, 1'b0, 0, 1, 1'b0, 8'h00, 32'h0230_0000};
    vecs[4] = '{32'h1A40_0001, 1'b1, 0, 2, 1'b0, 8'hA5, 32'h1340_00A5};
    vecs[5] = '{32'h9A50_1234, 1'b0, 0, 0, 1'b0, 8'h00, 32'h0150_0000};
    vecs[6] = '{32'h1A60_5500, 1'b0, 0, 5, 1'b1, 8'h00, 32'h2360_0000};
    vecs[7] = '{32'h1A70_7700, 1'b0, 1, 0, 1'b0, 8'h00, 32'h0170_0000};

    // Reset values.
    repeat (3) @(negedge clk);
    check32("rst_push_ready", 32'(push_ready), 32'd1);
    check32("rst_ctrl_data", ctrl_data, 32'd0);
    check32("rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
    check32("rst_read", 32'(read), 32'd0);
    check32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("rst_rsp_data", rsp_data, 32'd0);
    check32("rst_level", 32'(level), 32'd0);
    check32("rst_idle", 32'(idle), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Issue latency: pop at N+1, wr_ctrl high only during cycle N+2.
    sb.push_back(32'h0110_0000);
    push_one(32'h1A10_5500, 1'b0);
    @(posedge clk); #1;
    check32("lat_level_popped", 32'(level), 32'd0);
    check32("lat_ctrl_data", ctrl_data, 32'h1A10_5500);
    check32("lat_wr_ctrl_n1", 32'(wr_ctrl), 32'd0);
    @(posedge clk); #1;
    check32("lat_wr_ctrl_n2", 32'(wr_ctrl), 32'd1);
    @(posedge clk); #1;
    check32("lat_wr_ctrl_n3", 32'(wr_ctrl), 32'd0);
    drain("lat_rsp");

    // Vector table: ACK, read, NACK retries, lost strobe.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drop_base  = pulses;
      drop_limit = vecs[i].drops;
      nack_base  = acc;
      nack_limit = vecs[i].nacks;
      nack_data  = vecs[i].dn;
      m_rdata    = vecs[i].rdata;
      p0         = pulses;
      nr         = (vecs[i].nacks > int'(RETRIES)) ? int'(RETRIES) : vecs[i].nacks;
      exp_p      = vecs[i].drops + nr + 1;
      sb.push_back(vecs[i].exp);
      push_one(vecs[i].cmd, vecs[i].rd);
      drain($sformatf("vec%0d_rsp", i));
      check32($sformatf("vec%0d_pulses", i), 32'(pulses - p0), 32'(exp_p));
      for (int k = p0; k < pulses; k++) begin
        check32($sformatf("vec%0d_ctrl_data", i), p_ctrl_q[k][31:0], vecs[i].cmd);
        check32($sformatf("vec%0d_read", i), 32'(p_ctrl_q[k][32]), 32'(vecs[i].rd));
        if (vecs[i].drops == 0 && k > p0)
          check_ge($sformatf("vec%0d_backoff_gap", i), p_idle_q[k], int'(BACKOFF));
      end
    end

    // Response backpressure: nothing new issued while a response waits.
    @(negedge clk);
    nack_limit = 0;
    drop_limit = 0;
    m_rdata    = 8'h00;
    sb.push_back(32'h0180_0000);
    sb.push_back(32'h0181_0000);
    push_one(32'h1A80_AA00, 1'b0);
    begin
      bit ok;
      wait_valid("bp_first_valid", ok);
    end
    p0 = pulses;
    push_one(32'h1A81_BB00, 1'b0);
    repeat (50) @(negedge clk);
    check32("bp_no_issue", 32'(pulses - p0), 32'd0);
    check32("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check32("bp_rsp_data", rsp_data, 32'h0180_0000);
    check32("bp_level", 32'(level), 32'd1);
    drain("bp_rsp_a");
    drain("bp_rsp_b");

    // FIFO full and wrap while the master reports initializing.
    @(negedge clk);
    m_init = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sb.push_back({8'h01, 8'(k), 16'h0000});
      push_one({8'h1A, 8'(k), 16'h0000}, 1'b0);
    end
    @(negedge clk);
    check32("full_level", 32'(level), 32'd8);
    check32("full_push_ready", 32'(push_ready), 32'd0);
    p0 = pulses;
    push_one(32'h1AFF_0000, 1'b0);
    repeat (20) @(negedge clk);
    check32("full_ninth_ignored", 32'(level), 32'd8);
    check32("init_no_issue", 32'(pulses - p0), 32'd0);
    m_init = 1'b0;
    for (int k = 0; k < 8; k++) drain($sformatf("full_rsp%0d", k));
    @(negedge clk);
    m_init = 1'b1;
    for (int k = 8; k < 12; k++) begin
      sb.push_back({8'h01, 8'(k), 16'h0000});
      push_one({8'h1A, 8'(k), 16'h0000}, 1'b0);
    end
    @(negedge clk);
    check32("wrap_level", 32'(level), 32'd4);
    m_init = 1'b0;
    for (int k = 8; k < 12; k++) drain($sformatf("wrap_rsp%0d", k));

    // Flush with three queued; in-flight command still answers once.
    @(negedge clk);
    m_hold = 1'b1;
    p0 = pulses;
    sb.push_back(32'h0190_0000);
    for (int k = 0; k < 4; k++) push_one({8'h1A, 8'(8'h90 + 8'(k)), 16'h0000}, 1'b0);
    repeat (5) @(negedge clk);
    check32("flush_pre_level", 32'(level), 32'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check32("flush_level", 32'(level), 32'd0);
    repeat (5) @(negedge clk);
    m_hold = 1'b0;
    drain("flush_inflight_rsp");
    repeat (40) @(negedge clk);
    check32("flush_single_rsp", 32'(rsp_valid), 32'd0);
    check32("flush_single_issue", 32'(pulses - p0), 32'd1);
    check32("flush_idle", 32'(idle), 32'd1);

    // Asynchronous reset while waiting for the master to finish.
    @(negedge clk);
    m_hold = 1'b1;
    push_one(32'h1AA0_0000, 1'b0);
    push_one(32'h1AA1_0000, 1'b0);
    repeat (10) @(negedge clk);
    check32("rstmid_pre_level", 32'(level), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check32("rstmid_wr_ctrl", 32'(wr_ctrl), 32'd0);
    check32("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("rstmid_level", 32'(level), 32'd0);
    check32("rstmid_push_ready", 32'(push_ready), 32'd1);
    check32("rstmid_ctrl_data", ctrl_data, 32'd0);
    check32("rstmid_idle", 32'(idle), 32'd1);
    @(negedge clk);
    m_hold = 1'b0;
    reset  = 1'b0;
    repeat (20) @(negedge clk);
    check32("rstmid_no_rsp", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
